// File: rtl/countdown_ctrl_if.sv
// countdown_ctrl_if: button pulses in, timer/status out for the countdown controller
//   btn_start/btn_min/btn_sec/btn_clear : single-cycle command pulses
//   timer[11:0] : remaining seconds
//   state[1:0]  : 0=SET 1=RUN 2=PAUSE 3=EXPIRED
//   running/done/alarm : status flags
interface countdown_ctrl_if;
    logic        btn_start;
    logic        btn_min;
    logic        btn_sec;
    logic        btn_clear;
    logic [11:0] timer;
    logic [1:0]  state;
    logic        running;
    logic        done;
    logic        alarm;
    modport master (output btn_start, btn_min, btn_sec, btn_clear,
                    input  timer, state, running, done, alarm);
    modport slave  (input  btn_start, btn_min, btn_sec, btn_clear,
                    output timer, state, running, done, alarm);
endinterface

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: set/start/pause/clear sequencing, per-second countdown and expiry alarm
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : countdown_ctrl_if.slave (button pulses in; timer, state, running, done, alarm out)
module countdown_ctrl #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int MAX_TIME      = 3599,
    parameter int ALARM_SECS    = 5
) (
    input logic              clk,
    input logic              rst_n,
    countdown_ctrl_if.slave  bus
);
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int AW = (ALARM_SECS > 0) ? $clog2(ALARM_SECS + 1) : 1;
    localparam logic [11:0] MAX_T   = 12'(MAX_TIME);
    localparam logic [11:0] MIN_LIM = 12'(MAX_TIME - 60);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [AW-1:0] ALM_LAST = AW'(ALARM_SECS - 1);

    typedef enum logic [1:0] {SET, RUN, PAUSE, EXPIRED} state_t;

    state_t        st, st_n;
    logic [11:0]   tmr, tmr_n;
    logic [PW-1:0] pre, pre_n;
    logic [AW-1:0] acnt, acnt_n;
    logic          done_r, done_n;
    logic          tick;

    assign tick = (pre == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= SET;
            tmr    <= '0;
            pre    <= '0;
            acnt   <= '0;
            done_r <= 1'b0;
        end else begin
            st     <= st_n;
            tmr    <= tmr_n;
            pre    <= pre_n;
            acnt   <= acnt_n;
            done_r <= done_n;
        end
    end

    // Only the highest-priority command acts: clear > start > min > sec.
    always_comb begin
        st_n   = st;
        tmr_n  = tmr;
        pre_n  = pre;
        acnt_n = acnt;
        done_n = 1'b0;
        case (st)
            SET: begin
                if (bus.btn_clear)
                    tmr_n = '0;
                else if (bus.btn_start) begin
                    if (tmr != '0) begin
                        st_n  = RUN;
                        pre_n = '0;
                    end
                end else if (bus.btn_min)
                    tmr_n = (tmr <= MIN_LIM) ? tmr + 12'd60 : tmr;
                else if (bus.btn_sec)
                    tmr_n = (tmr < MAX_T) ? tmr + 12'd1 : tmr;
            end
            RUN: begin
                if (bus.btn_clear) begin
                    tmr_n = '0;
                    st_n  = SET;
                end else if (bus.btn_start)
                    st_n = PAUSE;           // prescaler held so no partial second is lost
                else begin
                    pre_n = tick ? '0 : pre + 1'b1;
                    if (tick && tmr != '0) begin
                        tmr_n = tmr - 12'd1;
                        if (tmr == 12'd1) begin
                            st_n   = EXPIRED;
                            done_n = 1'b1;
                            pre_n  = '0;
                            acnt_n = '0;
                        end
                    end
                end
            end
            PAUSE: begin
                if (bus.btn_clear) begin
                    tmr_n = '0;
                    st_n  = SET;
                end else if (bus.btn_start)
                    st_n = RUN;
            end
            EXPIRED: begin
                if (bus.btn_clear || bus.btn_start) begin
                    tmr_n = '0;
                    st_n  = SET;
                end else begin
                    pre_n = tick ? '0 : pre + 1'b1;
                    if (tick) begin
                        if (acnt == ALM_LAST)
                            st_n = SET;
                        else
                            acnt_n = acnt + 1'b1;
                    end
                end
            end
            default: st_n = SET;
        endcase
    end

    // Flags are decoded from registered state, so they stay registered outputs.
    assign bus.timer   = tmr;
    assign bus.state   = st;
    assign bus.running = (st == RUN);
    assign bus.alarm   = (st == EXPIRED);
    assign bus.done    = done_r;
endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: directed checks of countdown_ctrl with 4-cycle seconds and a 2-second alarm
module tb_countdown_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_tests = 0;
    int n_fail = 0;

    countdown_ctrl_if bus();

    countdown_ctrl #(.TICKS_PER_SEC(4), .MAX_TIME(3599), .ALARM_SECS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Starts and ends just after a falling edge; the pulse is sampled on the rising edge between.
    task automatic press(input logic s, input logic m, input logic sc, input logic c);
        bus.btn_start = s;
        bus.btn_min   = m;
        bus.btn_sec   = sc;
        bus.btn_clear = c;
        @(negedge clk);
        bus.btn_start = 1'b0;
        bus.btn_min   = 1'b0;
        bus.btn_sec   = 1'b0;
        bus.btn_clear = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic secs(input int n);
        for (int i = 0; i < n; i++) press(0, 0, 1, 0);
    endtask

    initial begin
        bus.btn_start = 1'b0;
        bus.btn_min   = 1'b0;
        bus.btn_sec   = 1'b0;
        bus.btn_clear = 1'b0;
        idle(2);
        check("rst_timer", bus.timer, 0);
        check("rst_state", bus.state, 0);
        check("rst_flags", {bus.running, bus.done, bus.alarm}, 0);
        rst_n = 1'b1;
        idle(1);

        press(1, 0, 0, 0);
        check("start_zero_state", bus.state, 0);

        press(0, 1, 0, 0);
        press(0, 1, 0, 0);
        secs(3);
        check("set_timer", bus.timer, 123);
        check("set_state", bus.state, 0);
        check("set_running", bus.running, 0);
        press(0, 1, 1, 0);
        check("prio_min_over_sec", bus.timer, 183);
        press(0, 0, 0, 1);
        check("clear_set", bus.timer, 0);

        secs(3);
        press(1, 0, 0, 0);
        check("run_state", bus.state, 1);
        check("run_running", bus.running, 1);
        check("run_t3", bus.timer, 3);
        idle(3);
        check("run_t3_hold", bus.timer, 3);
        idle(1);
        check("run_t2", bus.timer, 2);
        idle(4);
        check("run_t1", bus.timer, 1);
        idle(3);
        check("done_before", bus.done, 0);
        idle(1);
        check("exp_timer", bus.timer, 0);
        check("exp_done", bus.done, 1);
        check("exp_state", bus.state, 3);
        check("exp_alarm", bus.alarm, 1);
        check("exp_running", bus.running, 0);
        idle(1);
        check("done_after", bus.done, 0);
        check("alarm_2", bus.alarm, 1);
        idle(6);
        check("alarm_8", bus.alarm, 1);
        check("alarm_8_state", bus.state, 3);
        idle(1);
        check("alarm_end_state", bus.state, 0);
        check("alarm_end", bus.alarm, 0);

        secs(2);
        press(1, 0, 0, 0);
        idle(2);
        press(1, 0, 0, 0);
        check("pause_state", bus.state, 2);
        check("pause_running", bus.running, 0);
        idle(20);
        check("pause_hold_timer", bus.timer, 2);
        check("pause_hold_state", bus.state, 2);
        press(0, 1, 1, 0);
        check("pause_ignore_min", bus.timer, 2);
        press(1, 0, 0, 0);
        check("resume_state", bus.state, 1);
        idle(1);
        check("resume_no_dec", bus.timer, 2);
        idle(1);
        check("resume_dec", bus.timer, 1);

        press(1, 0, 0, 1);
        check("clr_start_timer", bus.timer, 0);
        check("clr_start_state", bus.state, 0);

        secs(3);
        press(1, 0, 0, 0);
        idle(3);
        press(1, 0, 0, 0);
        check("tick_pause_state", bus.state, 2);
        check("tick_pause_timer", bus.timer, 3);
        press(0, 0, 0, 1);
        check("pause_clear", bus.state, 0);

        secs(1);
        press(1, 0, 0, 0);
        idle(4);
        check("exp2_state", bus.state, 3);
        press(1, 0, 0, 0);
        check("exp_start_state", bus.state, 0);
        check("exp_start_alarm", bus.alarm, 0);

        secs(3599);
        check("sat_sec_fill", bus.timer, 3599);
        press(0, 0, 1, 0);
        check("sat_sec", bus.timer, 3599);
        press(0, 1, 0, 0);
        check("sat_min", bus.timer, 3599);
        press(0, 0, 0, 1);
        for (int i = 0; i < 59; i++) press(0, 1, 0, 0);
        check("min_59", bus.timer, 3540);
        press(0, 1, 0, 0);
        check("min_limit", bus.timer, 3540);
        press(0, 0, 0, 1);

        secs(50);
        press(1, 0, 0, 0);
        idle(5);
        check("pre_rst_timer", bus.timer, 49);
        #2 rst_n = 1'b0;
        #1;
        check("async_timer", bus.timer, 0);
        check("async_state", bus.state, 0);
        check("async_flags", {bus.running, bus.done, bus.alarm}, 0);
        idle(2);
        check("rst_hold_done", bus.done, 0);
        rst_n = 1'b1;
        idle(5);
        check("post_rst_state", bus.state, 0);
        check("post_rst_timer", bus.timer, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
Sequencing controller for the countdown timer. It owns the 12-bit seconds count `timer` that feeds the min/sec digit decoder. It handles:
- the user set / start / pause / clear commands,
- the once-per-second decrement from a clock prescaler,
- the expiry alarm window.

It sits between the debounced button pulses and the display decoder.

Parameters:
TICKS_PER_SEC, 50000000, clk cycles per one-second tick (use 4 in simulation)
MAX_TIME, 3599, largest settable timer value in seconds (59:59)
ALARM_SECS, 5, seconds alarm stays asserted after expiry

Ports:
clk        input   1   system clock, rising edge
rst_n      input   1   asynchronous active-low reset
btn_start  input   1   single-cycle pulse; start/pause toggle
btn_min    input   1   single-cycle pulse; add one minute (SET only)
btn_sec    input   1   single-cycle pulse; add one second (SET only)
btn_clear  input   1   single-cycle pulse; clear timer, return to SET
timer      output  12  remaining seconds, registered, to decoder
state      output  2   0=SET 1=RUN 2=PAUSE 3=EXPIRED
running    output  1   high while state==RUN
done       output  1   one-cycle pulse on expiry
alarm      output  1   high throughout EXPIRED

Behaviour:
- Reset (rst_n low, async): timer=0, state=SET, running=0, done=0, alarm=0, prescaler=0, alarm second counter=0.
- All outputs are registered. Commands take effect on the clock edge where the pulse is sampled, so outputs change one cycle after the pulse.
- Command priority within one cycle: btn_clear > btn_start > btn_min > btn_sec. Only the highest-priority active command acts; the others are dropped.
- Prescaler counts 0..TICKS_PER_SEC-1 and then wraps to 0. The wrap cycle is the "tick".
  - Counts only in RUN and EXPIRED.
  - Held in PAUSE.
  - Cleared on entry to RUN from SET and on entry to EXPIRED.
- SET:
  - btn_min: timer += 60 if timer <= MAX_TIME-60, else unchanged (saturate, no wrap).
  - btn_sec: timer += 1 if timer < MAX_TIME, else unchanged.
  - btn_clear: timer = 0.
  - btn_start with timer != 0: go to RUN, prescaler = 0.
  - btn_start with timer == 0: ignored.
- RUN:
  - On tick, timer -= 1.
  - If the decrement takes timer 1 -> 0: go to EXPIRED, and done = 1 in the first cycle that timer reads 0 (exactly one cycle).
  - btn_start: go to PAUSE, keep the prescaler value. If a tick coincides with btn_start, the pause wins and there is no decrement.
  - btn_clear: timer = 0, go to SET. A clear coinciding with a tick means no decrement and no done.
  - btn_min / btn_sec: ignored.
- PAUSE:
  - timer frozen.
  - btn_start: go to RUN, prescaler resumes from its held value (no lost partial second).
  - btn_clear: timer = 0, go to SET.
  - btn_min / btn_sec: ignored.
- EXPIRED:
  - alarm = 1, timer stays 0.
  - Count ticks; after ALARM_SECS ticks, go to SET and alarm = 0.
  - btn_start or btn_clear: go to SET immediately, alarm = 0.
  - btn_min / btn_sec: ignored.
- timer never underflows. A decrement is never applied when timer == 0.
- Widths: prescaler is clog2(TICKS_PER_SEC) bits; alarm counter is clog2(ALARM_SECS+1) bits. Comparisons are unsigned.
- Reset asserted mid-operation: immediate return to reset values regardless of state; no done pulse.

Test Plan (TICKS_PER_SEC=4, ALARM_SECS=2):
1. Reset, then btn_min x2 and btn_sec x3 (separate cycles) -> timer=123, state=SET, running=0.
2. From timer=3, btn_start -> state=RUN next cycle; timer reads 2, 1, 0 at 4-cycle intervals. done=1 for exactly one cycle when timer first reads 0. state=EXPIRED, alarm=1 for 8 cycles, then state=SET, alarm=0.
3. Set timer=2, start, wait 2 cycles, btn_start -> PAUSE with timer=2 held for 20 cycles. btn_start -> RUN; first decrement arrives 2 cycles later (prescaler resumed).
4. Saturation: btn_sec x3599, then btn_min -> timer=3599. Further btn_sec and btn_min leave timer=3599.
5. Simultaneous events:
   - btn_clear with btn_start in RUN -> timer=0, state=SET.
   - btn_start coinciding with a tick in RUN -> PAUSE, no decrement.
   - btn_start in SET with timer=0 -> remains SET.
6. rst_n pulsed low asynchronously mid-RUN (timer=50) -> timer=0, state=SET, all flags 0 before the next clk edge; no done pulse.
